// File: rtl/countdown16_1clk_sync_reset_pkg.sv
// Shared definitions for the counter family.
//   - state_t      : control FSM encoding for the down counter
//   - CNT_WIDTH_DEF: default counter width, also used by the up counters
package countdown16_1clk_sync_reset_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : countdown16_1clk_sync_reset_pkg

// File: rtl/countdown16_1clk_sync_reset.sv
// Loadable down counter with terminal-count pulse, auto-reload (periodic)
// and one-shot modes. Used as a timeout / period generator.
//
// Ports:
//   clock0        in   clock, all state updates on posedge
//   reset         in   synchronous reset, active-high
//   load          in   capture load_value into count and reload register
//   load_value    in   [WIDTH] start / reload value
//   enable        in   decrement qualifier; count holds when low
//   mode_periodic in   1 = reload on terminal count, 0 = one-shot
//   count         out  [WIDTH] current counter value (registered)
//   tc            out  one-cycle terminal-count pulse (registered)
//   busy          out  high while in RUN
//   done          out  high while in DONE
//
// Edge priority: reset > load > terminal event > decrement > hold.
module countdown16_1clk_sync_reset
  import countdown16_1clk_sync_reset_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             mode_periodic,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;

  // Terminal event: last enabled decrement while running.
  logic term_evt;
  assign term_evt = (state_q == ST_RUN) && enable && (count_q == ONE);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // A load wins over a coincident terminal event, so no tc for it.
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // enable ignored; count holds
        end
        ST_RUN: begin
          if (term_evt) begin
            tc_d = 1'b1;
            if (mode_periodic) begin
              count_d = reload_q;
            end else begin
              count_d = ZERO;
              state_d = ST_DONE;
            end
          end else if (enable && (count_q != ZERO)) begin
            // count is never 0 in RUN; the guard just makes wrap impossible.
            count_d = count_q - ONE;
          end
        end
        ST_DONE: begin
          count_d = ZERO;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Straight decodes of flops: no input-to-output combinational path.
  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule : countdown16_1clk_sync_reset

// File: tb/tb_countdown16_1clk_sync_reset.sv
module tb_countdown16_1clk_sync_reset;

  localparam int W = 16;

  logic         clock0 = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         mode_periodic = 1'b0;
  logic [W-1:0] count;
  logic         tc, busy, done;

  int checks = 0;
  int errors = 0;

  countdown16_1clk_sync_reset #(.WIDTH(W)) dut (
    .clock0       (clock0),
    .reset        (reset),
    .load         (load),
    .load_value   (load_value),
    .enable       (enable),
    .mode_periodic(mode_periodic),
    .count        (count),
    .tc           (tc),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock0 = ~clock0;

  // Advance one active edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic per);
    load = 1'b1; load_value = v; mode_periodic = per;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; enable = 1'b1;
    step(); step();
    checks++;
    if (count !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d busy=%b done=%b tc=%b, want 0 0 0 0", count, busy, done, tc);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (count !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: count=%0d busy=%b done=%b tc=%b, want 0 0 0 0", i, count, busy, done, tc);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_cnt [6] = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    enable = 1'b1;
    do_load(16'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (count !== exp_cnt[i] || tc !== (i == 5) || busy !== (i != 5) || done !== (i == 5)) begin
        errors++;
        $display("FAIL one_shot[%0d]: count=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                 i, count, tc, busy, done, exp_cnt[i], (i == 5), (i != 5), (i == 5));
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (count !== 16'd0 || tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL one_shot_hold[%0d]: count=%0d tc=%b done=%b busy=%b, want 0 0 1 0", i, count, tc, done, busy);
      end
    end
  endtask

  task automatic test_periodic_gaps();
    logic         en_seq  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] exp_cnt [7] = '{16'd2, 16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3};
    logic         exp_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    enable = 1'b0;
    do_load(16'd3, 1'b1);
    checks++;
    if (count !== 16'd3 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL periodic_load: count=%0d busy=%b tc=%b, want 3 1 0", count, busy, tc);
    end
    for (int i = 0; i < 7; i++) begin
      enable = en_seq[i];
      step();
      checks++;
      if (count !== exp_cnt[i] || tc !== exp_tc[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL periodic[%0d]: count=%0d tc=%b busy=%b done=%b, want %0d %b 1 0",
                 i, count, tc, busy, done, exp_cnt[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_load_collision();
    enable = 1'b1;
    do_load(16'd2, 1'b1);
    step();
    checks++;
    if (count !== 16'd1) begin
      errors++;
      $display("FAIL collision_setup: count=%0d, want 1", count);
    end
    load = 1'b1; load_value = 16'd9; enable = 1'b1;
    step();
    load = 1'b0; enable = 1'b0;
    checks++;
    if (count !== 16'd9 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_collision: count=%0d tc=%b busy=%b, want 9 0 1", count, tc, busy);
    end
    step();
    checks++;
    if (count !== 16'd9 || tc !== 1'b0) begin
      errors++;
      $display("FAIL collision_after: count=%0d tc=%b, want 9 0", count, tc);
    end
  endtask

  task automatic test_reload_one();
    enable = 1'b1;
    do_load(16'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (count !== 16'd1 || tc !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload_one[%0d]: count=%0d tc=%b busy=%b, want 1 1 1", i, count, tc, busy);
      end
    end
    // mode sampled only at the terminal edge: switch to one-shot now
    mode_periodic = 1'b0;
    step();
    checks++;
    if (count !== 16'd0 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mode_switch: count=%0d tc=%b done=%b busy=%b, want 0 1 1 0", count, tc, done, busy);
    end
  endtask

  task automatic test_zero_load();
    enable = 1'b1;
    do_load(16'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count !== 16'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_load[%0d]: count=%0d tc=%b busy=%b done=%b, want 0 0 0 0", i, count, tc, busy, done);
      end
      step();
    end
  endtask

  task automatic test_max_load();
    int edges = 0;
    enable = 1'b1;
    do_load(16'hFFFF, 1'b0);
    while (tc !== 1'b1 && edges < 70000) begin
      step();
      edges++;
    end
    checks++;
    if (edges !== 65535 || count !== 16'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL max_load: edges=%0d count=%0d done=%b, want 65535 0 1", edges, count, done);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    do_load(16'd10, 1'b1);
    step(); step(); step();
    checks++;
    if (count !== 16'd7) begin
      errors++;
      $display("FAIL reset_mid_setup: count=%0d, want 7", count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (count !== 16'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d busy=%b tc=%b done=%b, want 0 0 0 0", count, busy, tc, done);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== 16'd0 || busy !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold[%0d]: count=%0d busy=%b tc=%b, want 0 0 0", i, count, busy, tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic_gaps();
    test_load_collision();
    test_reload_one();
    test_zero_load();
    test_max_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_countdown16_1clk_sync_reset

// File: doc/countdown16_1clk_sync_reset.md
Name: countdown16_1clk_sync_reset

Overview:
- Loadable 16-bit down counter with terminal-count detection, auto-reload and one-shot modes.
- Mirrors the team's free-running up counter: it counts a programmed value down to zero instead of up from zero.
- Used as a timeout/period generator beside the up counters.
- Single clock; a small three-state control FSM wraps the count register.

Parameters:
- WIDTH, 16, counter and load-value width in bits.

Ports:
- clock0  input  1  clock, all state updates on posedge
- reset  input  1  synchronous reset, active-high
- load  input  1  capture load_value into count and reload register
- load_value  input  WIDTH  start/reload value
- enable  input  1  decrement qualifier; count holds when low
- mode_periodic  input  1  1 = auto-reload on terminal count, 0 = one-shot
- count  output  WIDTH  current counter value (registered)
- tc  output  1  terminal-count pulse, one cycle wide (registered)
- busy  output  1  high while in RUN
- done  output  1  high while in DONE (one-shot finished)

Behaviour:
- Interface:
  - One clock; reset is synchronous and active-high.
  - Clock port is clock0; reset port is reset.
  - All outputs are registered; there are no combinational input-to-output paths.
- Reset (reset=1 at posedge clock0):
  - state=IDLE, count=0, reload_reg=0, tc=0, busy=0, done=0.
  - Reset overrides every other input.
- Priority per edge: reset > load > terminal event > decrement > hold.
- FSM states are IDLE, RUN and DONE. busy = (state==RUN); done = (state==DONE).
- load=1, any state:
  - count <= load_value and reload_reg <= load_value.
  - load_value != 0 -> state RUN; load_value == 0 -> state IDLE.
  - tc=0 on the following cycle.
  - A load coinciding with a terminal event suppresses the tc for that event.
- IDLE: count holds; enable is ignored.
- RUN, enable=0: count holds; tc=0.
- RUN, enable=1, count>1: count <= count-1; tc=0.
- RUN, enable=1, count==1 (terminal event):
  - tc=1 for exactly the next cycle.
  - mode_periodic is sampled on this edge.
  - mode_periodic=1: count <= reload_reg; stay in RUN. The period is reload_reg enabled cycles.
  - mode_periodic=0: count <= 0; state DONE.
- DONE: count holds at 0; tc=0; done stays high until load or reset.
- Periodic mode with reload_reg=1: tc is high on every cycle that follows an enabled edge.
- mode_periodic may change at any time; only its value at a terminal edge matters.
- Arithmetic and width:
  - Unsigned, WIDTH bits.
  - count never underflows; the 0 -> 0xFFFF wrap is unreachable by design.
  - Maximum load 0xFFFF gives 65535 enabled cycles to tc.
- Reset mid-count: the count is lost and reload_reg is cleared; a new load is required.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH=16, reused by the up-counter family.
- No sub-module. The count register, reload register and FSM are small enough for one module.

Test Plan:
- Reset then idle: reset=1 for 2 edges, then load=0, enable=1 for 10 cycles -> count=0, busy=0, done=0, tc never asserted.
- One-shot: load 5, mode_periodic=0, enable=1 -> count 5,4,3,2,1,0; tc high one cycle exactly when count first reads 0; done=1 and busy=0 from that cycle; count stays 0 for 20 more cycles.
- Periodic with gaps: load 3, mode_periodic=1, enable toggled 1,0,1,1,1,1,1 -> count 3,2,2,1,3,2,1,3; tc high on the cycles count reloads to 3; busy stays 1.
- Load collision: periodic, count=1, enable=1, load=1 with load_value=9 on the same edge -> count=9, no tc pulse, state RUN.
- Zero and max load:
  - load 0 -> IDLE, count=0, no tc.
  - load 0xFFFF, one-shot, enable held -> tc exactly 65535 edges after load, count=0.
- Reset mid-operation: periodic run at count=7, assert reset one edge -> count=0, busy=0, tc=0; with enable=1 and no new load, count stays 0.
